// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters (CPU port C, debug port D), the
// arbiter and the memory array. The arbiter takes the slave modport; the
// requester/memory side takes the master modport.
interface mem_port_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 32
);
  // port C (CPU)
  logic          c_req;
  logic          c_we;
  logic [31:0]   c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_ack;
  logic          c_err;
  logic [DW-1:0] c_rdata;
  // port D (debug/loader)
  logic          d_req;
  logic          d_we;
  logic [31:0]   d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic          d_err;
  logic [DW-1:0] d_rdata;
  // memory side
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  // status
  logic          busy;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_ack, c_err, c_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_ack, d_err, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_ack, c_err, c_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_ack, d_err, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of the unified word-addressed memory.
// Port C is the multi-cycle CPU, port D the debug/loader port. Each granted
// access is alignment/range checked, then issued to memory as a single
// mem_en strobe; reads wait a fixed MEM_LAT (1..7) cycles for data.
// Every output is a register, so all _d values describe the next cycle.
module mem_port_arbiter #(
  parameter int AW      = 12,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,   // asynchronous, active low
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  // Wait counter preload: the last WAIT cycle (cnt==0) is the one in which
  // mem_rdata is valid, MEM_LAT cycles after the ISSUE cycle.
  localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 1);

  state_t        state_q, state_d;
  logic          last_gnt_q, last_gnt_d;   // 0 = C, 1 = D
  logic          sel_q, sel_d;             // port owning the transaction
  logic          we_q, we_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          c_ack_q, c_ack_d;
  logic          d_ack_q, d_ack_d;
  logic          c_err_q, c_err_d;
  logic          d_err_q, d_err_d;
  logic [DW-1:0] c_rdata_q, c_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          busy_q, busy_d;

  // Grant decision and the request fields of the would-be winner. Only the
  // winner's fields reach the mem_* registers, so the losing port's inputs
  // cannot leak onto the memory bus.
  logic          any_req;
  logic          gnt_sel;
  logic          req_we;
  logic [31:0]   req_addr;
  logic [DW-1:0] req_wdata;
  logic          addr_bad;

  assign any_req   = bus.c_req | bus.d_req;
  // On a tie the port that did not win last time gets it; last_gnt resets
  // to D so the first tie goes to C.
  assign gnt_sel   = (bus.c_req & bus.d_req) ? ~last_gnt_q : bus.d_req;
  assign req_we    = gnt_sel ? bus.d_we    : bus.c_we;
  assign req_addr  = gnt_sel ? bus.d_addr  : bus.c_addr;
  assign req_wdata = gnt_sel ? bus.d_wdata : bus.c_wdata;
  // Misaligned byte address, or any bit above the memory's word range set.
  assign addr_bad  = (req_addr[1:0] != 2'b00) |
                     ((req_addr >> (AW + 2)) != 32'd0);

  // Next-state and next-output logic; strobes default low, data holds.
  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    sel_d       = sel_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    c_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    c_err_d     = 1'b0;
    d_err_d     = 1'b0;
    c_rdata_d   = c_rdata_q;
    d_rdata_d   = d_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          sel_d      = gnt_sel;
          we_d       = req_we;
          last_gnt_d = gnt_sel;
          if (addr_bad) begin
            // Rejected without touching memory: error ack next cycle.
            state_d = DONE;
            c_ack_d = ~gnt_sel;
            d_ack_d = gnt_sel;
            c_err_d = ~gnt_sel;
            d_err_d = gnt_sel;
          end else begin
            state_d     = ISSUE;
            mem_en_d    = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = req_addr[AW+1:2];
            mem_wdata_d = req_wdata;
          end
        end
      end

      ISSUE: begin
        if (we_q) begin
          state_d = DONE;
          c_ack_d = ~sel_q;
          d_ack_d = sel_q;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end
      end

      WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = DONE;
          c_ack_d = ~sel_q;
          d_ack_d = sel_q;
          if (sel_q) d_rdata_d = bus.mem_rdata;
          else       c_rdata_d = bus.mem_rdata;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      DONE: begin
        // req is ignored here so a held req becomes a fresh request in IDLE.
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops any in-flight access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      last_gnt_q  <= 1'b1;
      sel_q       <= 1'b0;
      we_q        <= 1'b0;
      cnt_q       <= 3'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      c_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      c_err_q     <= 1'b0;
      d_err_q     <= 1'b0;
      c_rdata_q   <= '0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      c_ack_q     <= c_ack_d;
      d_ack_q     <= d_ack_d;
      c_err_q     <= c_err_d;
      d_err_q     <= d_err_d;
      c_rdata_q   <= c_rdata_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.c_ack     = c_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.c_err     = c_err_q;
  assign bus.d_err     = d_err_q;
  assign bus.c_rdata   = c_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = busy_q;

endmodule
